// File: rtl/hessian_layer_sched_pkg.sv
// Shared constants and state encoding for the hessian layer scheduler.
// PIPE_LATENCY is derived from the shared pipeline's two sub-stages.
package hessian_layer_sched_pkg;

    localparam int DERXX_LATENCY    = 5;
    localparam int DETH_LATENCY     = 4;
    localparam int PIPE_LATENCY_DEF = DERXX_LATENCY + DETH_LATENCY;
    localparam int N_REQ_DEF        = 4;
    localparam int IDX_W_DEF        = $clog2(N_REQ_DEF);
    localparam int CNT_W_DEF        = $clog2(PIPE_LATENCY_DEF + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Index increment with wrap at n.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/hessian_layer_sched_if.sv
// Requester / pipeline-facing signal bundle of the layer scheduler.
// master = corner fetchers + pipeline side, slave = the scheduler.
interface hessian_layer_sched_if
    import hessian_layer_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] mux_sel;
    logic             hess_din_valid;
    logic             hess_o_d_valid;
    logic             det_valid;
    logic [IDX_W-1:0] det_layer;
    logic [CNT_W-1:0] inflight;
    logic             flush_req;
    logic             flush_done;
    logic             tag_err;

    modport master (
        output en, req, hess_o_d_valid, flush_req,
        input  grant, mux_sel, hess_din_valid, det_valid, det_layer,
               inflight, flush_done, tag_err
    );

    modport slave (
        input  en, req, hess_o_d_valid, flush_req,
        output grant, mux_sel, hess_din_valid, det_valid, det_layer,
               inflight, flush_done, tag_err
    );
endinterface

// File: rtl/hessian_layer_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr,
// wrapping modulo N_REQ.
module hessian_layer_sched_rr_arbiter
    import hessian_layer_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hessian_layer_sched.sv
// Round-robin scheduler sharing one hessian determinant pipeline across
// scale layers; tags each issued beat so results come back labelled.
module hessian_layer_sched
    import hessian_layer_sched_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    hessian_layer_sched_if.slave bus
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PIPE_LATENCY-1:0] tv_q, tv_d;
    logic [IDX_W-1:0]        tidx_q [PIPE_LATENCY];
    logic [IDX_W-1:0]        tidx_d [PIPE_LATENCY];
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic                    flush_done_q, flush_done_d;
    logic                    tag_err_q, tag_err_d;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] win_grant;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             v_last;

    assign arb_req = (bus.en && state_q == ST_RUN) ? bus.req : '0;

    hessian_layer_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (arb_req),
        .rr_ptr (rr_ptr_q),
        .grant  (win_grant),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign v_last             = tv_q[PIPE_LATENCY-1];
    assign bus.grant          = win_grant;
    assign bus.mux_sel        = win_idx;
    assign bus.hess_din_valid = win_any;
    assign bus.det_valid      = bus.hess_o_d_valid & v_last;
    assign bus.det_layer      = tidx_q[PIPE_LATENCY-1];
    assign bus.inflight       = inflight_q;
    assign bus.flush_done     = flush_done_q;
    assign bus.tag_err        = tag_err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_any) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(win_idx), N_REQ));
        end

        tv_d      = {tv_q[PIPE_LATENCY-2:0], win_any};
        tidx_d[0] = win_idx;
        for (int i = 1; i < PIPE_LATENCY; i++) begin
            tidx_d[i] = tidx_q[i-1];
        end

        // Issue and retire in the same cycle cancel; bounds guard against drift.
        inflight_d = inflight_q;
        if (win_any && !v_last && inflight_q < CNT_W'(PIPE_LATENCY)) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!win_any && v_last && inflight_q != '0) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        tag_err_d = tag_err_q | (bus.hess_o_d_valid != v_last);

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        flush_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= '0;
            tv_q         <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tidx_q[i] <= '0;
            end
            inflight_q   <= '0;
            flush_done_q <= 1'b0;
            tag_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tv_q         <= tv_d;
            tidx_q       <= tidx_d;
            inflight_q   <= inflight_d;
            flush_done_q <= flush_done_d;
            tag_err_q    <= tag_err_d;
        end
    end

endmodule

// File: tb/tb_hessian_layer_sched.sv
// Directed bench for hessian_layer_sched with a 9-deep valid delay line
// standing in for the shared hessian pipeline.
module tb_hessian_layer_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inject = 1'b0;
    logic [8:0] hpipe;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hessian_layer_sched_if ifc ();

    hessian_layer_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Pipeline stand-in: reset together with the scheduler.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hpipe <= '0;
        else        hpipe <= {hpipe[7:0], ifc.hess_din_valid};
    end
    assign ifc.hess_o_d_valid = hpipe[8] | inject;

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        ifc.en = 1'b1;
        ifc.req = '0;
        ifc.flush_req = 1'b0;
        inject = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        ifc.req = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ifc.en = 1'b1;
        ifc.req = '0;
        ifc.flush_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (ifc.grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", ifc.grant); else passed++;
        checks++; if (ifc.hess_din_valid !== 1'b0) $display("FAIL reset_din_valid got %b exp 0", ifc.hess_din_valid); else passed++;
        checks++; if (ifc.mux_sel !== 2'd0) $display("FAIL reset_mux_sel got %0d exp 0", ifc.mux_sel); else passed++;
        checks++; if (ifc.inflight !== 4'd0) $display("FAIL reset_inflight got %0d exp 0", ifc.inflight); else passed++;
        checks++; if (ifc.flush_done !== 1'b0) $display("FAIL reset_flush_done got %b exp 0", ifc.flush_done); else passed++;
        checks++; if (ifc.tag_err !== 1'b0) $display("FAIL reset_tag_err got %b exp 0", ifc.tag_err); else passed++;
        checks++; if (ifc.det_valid !== 1'b0) $display("FAIL reset_det_valid got %b exp 0", ifc.det_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic exp_dv;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ifc.req = (k < 5) ? 4'b0010 : 4'b0000;
            #1;
            if (k < 5) begin
                checks++; if (ifc.grant !== 4'b0010) $display("FAIL single_grant k=%0d got %b exp 0010", k, ifc.grant); else passed++;
                checks++; if (ifc.mux_sel !== 2'd1) $display("FAIL single_mux_sel k=%0d got %0d exp 1", k, ifc.mux_sel); else passed++;
            end
            exp_dv = (k >= 9 && k <= 13);
            checks++; if (ifc.det_valid !== exp_dv) $display("FAIL single_det_valid k=%0d got %b exp %b", k, ifc.det_valid, exp_dv); else passed++;
            if (exp_dv) begin
                checks++; if (ifc.det_layer !== 2'd1) $display("FAIL single_det_layer k=%0d got %0d exp 1", k, ifc.det_layer); else passed++;
            end
            if (k == 5 || k == 9) begin
                checks++; if (ifc.inflight !== 4'd5) $display("FAIL single_inflight_peak k=%0d got %0d exp 5", k, ifc.inflight); else passed++;
            end
            if (k == 15) begin
                checks++; if (ifc.inflight !== 4'd0) $display("FAIL single_inflight_end got %0d exp 0", ifc.inflight); else passed++;
            end
        end
    endtask

    task automatic test_all_rr;
        logic exp_dv;
        logic [3:0] eg;
        logic [1:0] el;
        do_reset();
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            ifc.req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                eg = 4'b0001 << (k % 4);
                checks++; if (ifc.grant !== eg) $display("FAIL rr_grant k=%0d got %b exp %b", k, ifc.grant, eg); else passed++;
            end
            exp_dv = (k >= 9 && k <= 16);
            checks++; if (ifc.det_valid !== exp_dv) $display("FAIL rr_det_valid k=%0d got %b exp %b", k, ifc.det_valid, exp_dv); else passed++;
            if (exp_dv) begin
                el = 2'((k - 9) % 4);
                checks++; if (ifc.det_layer !== el) $display("FAIL rr_det_layer k=%0d got %0d exp %0d", k, ifc.det_layer, el); else passed++;
            end
        end
        checks++; if (ifc.tag_err !== 1'b0) $display("FAIL rr_tag_err got %b exp 0", ifc.tag_err); else passed++;
    endtask

    task automatic test_wrap;
        do_reset();
        @(negedge clk);
        ifc.req = 4'b0100;
        #1;
        checks++; if (ifc.grant !== 4'b0100) $display("FAIL wrap_setup got %b exp 0100", ifc.grant); else passed++;
        @(negedge clk);
        ifc.req = 4'b0101;
        #1;
        checks++; if (ifc.grant !== 4'b0001) $display("FAIL wrap_grant got %b exp 0001", ifc.grant); else passed++;
        checks++; if (ifc.mux_sel !== 2'd0) $display("FAIL wrap_mux_sel got %0d exp 0", ifc.mux_sel); else passed++;
        @(negedge clk);
        ifc.req = 4'b0101;
        #1;
        checks++; if (ifc.grant !== 4'b0100) $display("FAIL wrap_after got %b exp 0100", ifc.grant); else passed++;
        checks++; if (ifc.mux_sel !== 2'd2) $display("FAIL wrap_after_sel got %0d exp 2", ifc.mux_sel); else passed++;
        idle(12);
    endtask

    task automatic test_en;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ifc.en = (k == 1);
            ifc.req = (k == 1) ? 4'b0001 : 4'b1111;
            #1;
            if (k == 0 || k == 2) begin
                checks++; if (ifc.grant !== 4'b0000) $display("FAIL en_off_grant k=%0d got %b exp 0000", k, ifc.grant); else passed++;
                checks++; if (ifc.hess_din_valid !== 1'b0) $display("FAIL en_off_din k=%0d got %b exp 0", k, ifc.hess_din_valid); else passed++;
            end
            if (k == 1) begin
                checks++; if (ifc.grant !== 4'b0001) $display("FAIL en_on_grant got %b exp 0001", ifc.grant); else passed++;
            end
            if (k == 9) begin
                checks++; if (ifc.det_valid !== 1'b0) $display("FAIL en_early_det got %b exp 0", ifc.det_valid); else passed++;
            end
            if (k == 10) begin
                checks++; if (ifc.det_valid !== 1'b1) $display("FAIL en_off_det got %b exp 1", ifc.det_valid); else passed++;
            end
        end
        ifc.en = 1'b1;
        idle(3);
    endtask

    task automatic test_flush;
        logic [3:0] eg;
        logic exp_dv;
        logic exp_fd;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            ifc.req = 4'b0001;
            ifc.flush_req = (k >= 2 && k < 12);
            #1;
            eg = (k <= 2 || k == 13) ? 4'b0001 : 4'b0000;
            exp_dv = (k >= 9 && k <= 11);
            exp_fd = (k == 12);
            checks++; if (ifc.grant !== eg) $display("FAIL flush_grant k=%0d got %b exp %b", k, ifc.grant, eg); else passed++;
            checks++; if (ifc.det_valid !== exp_dv) $display("FAIL flush_det_valid k=%0d got %b exp %b", k, ifc.det_valid, exp_dv); else passed++;
            checks++; if (ifc.flush_done !== exp_fd) $display("FAIL flush_done k=%0d got %b exp %b", k, ifc.flush_done, exp_fd); else passed++;
        end
        ifc.flush_req = 1'b0;
        idle(12);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ifc.flush_req = (k < 2);
            #1;
            exp_fd = (k == 2);
            checks++; if (ifc.flush_done !== exp_fd) $display("FAIL flush_empty k=%0d got %b exp %b", k, ifc.flush_done, exp_fd); else passed++;
        end
    endtask

    task automatic test_tag_err;
        do_reset();
        @(negedge clk);
        inject = 1'b1;
        #1;
        checks++; if (ifc.det_valid !== 1'b0) $display("FAIL tag_det_valid got %b exp 0", ifc.det_valid); else passed++;
        checks++; if (ifc.tag_err !== 1'b0) $display("FAIL tag_err_early got %b exp 0", ifc.tag_err); else passed++;
        @(negedge clk);
        inject = 1'b0;
        #1;
        checks++; if (ifc.tag_err !== 1'b1) $display("FAIL tag_err_set got %b exp 1", ifc.tag_err); else passed++;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ifc.tag_err !== 1'b1) $display("FAIL tag_err_sticky got %b exp 1", ifc.tag_err); else passed++;
    endtask

    task automatic test_async_reset;
        logic exp_dv;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifc.req = 4'b1111;
        end
        @(negedge clk);
        ifc.req = 4'b0000;
        #1;
        checks++; if (ifc.inflight !== 4'd6) $display("FAIL areset_pre_inflight got %0d exp 6", ifc.inflight); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ifc.inflight !== 4'd0) $display("FAIL areset_inflight got %0d exp 0", ifc.inflight); else passed++;
        checks++; if (ifc.grant !== 4'b0000) $display("FAIL areset_grant got %b exp 0000", ifc.grant); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            checks++; if (ifc.det_valid !== 1'b0) $display("FAIL areset_det_valid k=%0d got %b exp 0", k, ifc.det_valid); else passed++;
        end
        checks++; if (ifc.tag_err !== 1'b0) $display("FAIL areset_tag_err got %b exp 0", ifc.tag_err); else passed++;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            ifc.req = (k == 0) ? 4'b0001 : 4'b0000;
            #1;
            exp_dv = (k == 9);
            checks++; if (ifc.det_valid !== exp_dv) $display("FAIL areset_fresh k=%0d got %b exp %b", k, ifc.det_valid, exp_dv); else passed++;
            if (exp_dv) begin
                checks++; if (ifc.det_layer !== 2'd0) $display("FAIL areset_fresh_layer got %0d exp 0", ifc.det_layer); else passed++;
            end
        end
    endtask

    initial begin
        ifc.en = 1'b1;
        ifc.req = '0;
        ifc.flush_req = 1'b0;
        test_reset();
        test_single();
        test_all_rr();
        test_wrap();
        test_en();
        test_flush();
        test_tag_err();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
